// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - RV32I execute-stage ALU with valid/ready handshake (option: ALU_BARREL_SHIFT_EN)
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [3:0] CTL_ADD  = 4'd0;
    localparam logic [3:0] CTL_SUB  = 4'd1;
    localparam logic [3:0] CTL_AND  = 4'd2;
    localparam logic [3:0] CTL_OR   = 4'd3;
    localparam logic [3:0] CTL_XOR  = 4'd4;
    localparam logic [3:0] CTL_SLT  = 4'd5;
    localparam logic [3:0] CTL_SLTU = 4'd6;
    localparam logic [3:0] CTL_SLL  = 4'd7;
    localparam logic [3:0] CTL_SRL  = 4'd8;
    localparam logic [3:0] CTL_SRA  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] comb_res;
    logic            comb_illegal;
    logic            is_shift;

    assign shamt = op_b[SHW-1:0];

    always_comb begin
        comb_res     = '0;
        comb_illegal = 1'b0;
        is_shift     = 1'b0;
        case (alu_ctl)
            CTL_ADD:  comb_res = op_a + op_b;
            CTL_SUB:  comb_res = op_a - op_b;
            CTL_AND:  comb_res = op_a & op_b;
            CTL_OR:   comb_res = op_a | op_b;
            CTL_XOR:  comb_res = op_a ^ op_b;
            CTL_SLT:  comb_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            CTL_SLTU: comb_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_BARREL_SHIFT_EN
            CTL_SLL: begin is_shift = 1'b1; comb_res = op_a << shamt; end
            CTL_SRL: begin is_shift = 1'b1; comb_res = op_a >> shamt; end
            CTL_SRA: begin is_shift = 1'b1; comb_res = XLEN'($signed(op_a) >>> shamt); end
`else
            // Serial mode: only a zero-amount shift finishes here, and it is a pass-through.
            CTL_SLL, CTL_SRL, CTL_SRA: begin is_shift = 1'b1; comb_res = op_a; end
`endif
            default:  comb_illegal = 1'b1;
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    localparam logic [SHW-1:0] CNT_LAST = SHW'(1);

    logic [SHW-1:0]  cnt;
    logic            sh_left;
    logic            sh_arith;
    logic            go_busy;
    logic [XLEN-1:0] step_res;

    assign go_busy = is_shift && (shamt != '0);

    // The result register doubles as the shift register while BUSY.
    always_comb begin
        step_res = '0;
        if (sh_left)
            step_res = {result[XLEN-2:0], 1'b0};
        else
            step_res = {(sh_arith & result[XLEN-1]), result[XLEN-1:1]};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            cnt       <= '0;
            sh_left   <= 1'b0;
            sh_arith  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        illegal  <= comb_illegal;
`ifndef ALU_BARREL_SHIFT_EN
                        if (go_busy) begin
                            result   <= op_a;
                            cnt      <= shamt;
                            sh_left  <= (alu_ctl == CTL_SLL);
                            sh_arith <= (alu_ctl == CTL_SRA);
                            state    <= BUSY;
                        end else
`endif
                        begin
                            result    <= comb_res;
                            zero      <= (comb_res == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                BUSY: begin
                    result <= step_res;
                    cnt    <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        zero      <= (step_res == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit (honours ALU_BARREL_SHIFT_EN)
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alu_ctl(alu_ctl),
        .op_a(op_a),
        .op_b(op_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zero(zero),
        .illegal(illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] ctl, input logic [31:0] b);
        int lat;
        lat = 1;
`ifndef ALU_BARREL_SHIFT_EN
        if ((ctl == 4'd7 || ctl == 4'd8 || ctl == 4'd9) && b[4:0] != 5'd0)
            lat = int'(b[4:0]) + 1;
`endif
        return lat;
    endfunction

    function automatic logic [31:0] model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        case (ctl)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << b[4:0];
            4'd8: return a >> b[4:0];
            4'd9: return 32'($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    // Drive one request; operands are scrambled right after accept to prove they were latched.
    task automatic issue(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        exp_t e;
        @(negedge clk);
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        alu_ctl  = ctl;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        e.res = res;
        e.z   = (res == 32'd0);
        e.ill = (ctl > 4'd9);
        e.lat = exp_lat(ctl, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctl  = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, 32'(lat), 32'(e.lat));
            check({tag, "_result"}, result, e.res);
            check({tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
            check({tag, "_illegal"}, {31'd0, illegal}, {31'd0, e.ill});
        end
        if (out_ready) begin
            @(negedge clk);
            check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
            check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    task automatic run(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input string tag);
        issue(ctl, a, b, res);
        collect(tag);
    endtask

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctl   = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "add_ovf");
        run(4'd1, 32'd5, 32'd5, 32'd0, "sub_zero");
        run(4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, "slt");
        run(4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, "sltu");
        run(4'd12, 32'h1234_5678, 32'h1111_1111, 32'd0, "illegal12");
        run(4'd0, 32'd1, 32'd1, 32'd2, "add_clears_illegal");
        run(4'd9, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra4");
        run(4'd7, 32'h0000_0001, 32'd31, 32'h8000_0000, "sll31");
        run(4'd8, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, "srl0");
        run(4'd8, 32'hF000_0000, 32'd28, 32'h0000_000F, "srl28");
        run(4'd2, 32'hF0F0_A5A5, 32'hFF00_0FF0, 32'hF000_05A0, "and");
        run(4'd3, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, "or");
        run(4'd4, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA, "xor");
        run(4'd15, 32'd0, 32'd0, 32'd0, "illegal15");

        for (int i = 0; i < 10; i++) begin
            rc = 4'($urandom_range(0, 11));
            ra = $urandom;
            rb = $urandom;
            run(rc, ra, rb, model(rc, ra, rb), "random");
        end

        out_ready = 1'b0;
        issue(4'd3, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
        collect("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            alu_ctl  = 4'd0;
            op_a     = 32'd1;
            op_b     = 32'd1;
            check("bp_result_stable", result, 32'h0000_00FF);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);

`ifndef ALU_BARREL_SHIFT_EN
        @(negedge clk);
        alu_ctl  = 4'd7;
        op_a     = 32'd1;
        op_b     = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("midrst_no_pulse", {31'd0, out_valid}, 32'd0);
        end
`endif
        run(4'd0, 32'd2, 32'd3, 32'd5, "add_after_rst");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
